// File: rtl/mdu_if.sv
// Execute-to-write-back connection of the multiply/divide unit.
// The master (issue logic and write-back) drives the i_* side; the mdu drives the o_* side.
interface mdu_if;
    logic        i_flush;
    logic        i_valid;
    logic [2:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [4:0]  i_rdidx;
    logic        i_wb_wait;
    logic        o_mdu_working;
    logic        o_rdwen;
    logic [4:0]  o_rdidx;
    logic [31:0] o_rdwdata;

    modport master (
        output i_flush, i_valid, i_op, i_rs1, i_rs2, i_rdidx, i_wb_wait,
        input  o_mdu_working, o_rdwen, o_rdidx, o_rdwdata
    );

    modport slave (
        input  i_flush, i_valid, i_op, i_rs1, i_rs2, i_rdidx, i_wb_wait,
        output o_mdu_working, o_rdwen, o_rdidx, o_rdwdata
    );
endinterface

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide
// on operand magnitudes, with the sign fixed up on the last step and the result held until write-back takes it.
module mdu (
    input  logic  i_clk,
    input  logic  i_rstn,
    mdu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rdidx_q, rdidx_d;
    logic        neg_q, neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [31:0] opb_q, opb_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;

    logic        signed1, signed2, sign1, sign2;
    logic [31:0] mag1, mag2;
    logic        div_zero, div_ovf;
    logic [32:0] mul_sum;
    logic [63:0] mul_next, product;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem, div_quo, quo_res, rem_res;

    always_comb begin
        signed1   = (bus.i_op == 3'b001) || (bus.i_op == 3'b010) ||
                    (bus.i_op == 3'b100) || (bus.i_op == 3'b110);
        signed2   = (bus.i_op == 3'b001) || (bus.i_op == 3'b100) || (bus.i_op == 3'b110);
        sign1     = signed1 & bus.i_rs1[31];
        sign2     = signed2 & bus.i_rs2[31];
        mag1      = sign1 ? -bus.i_rs1 : bus.i_rs1;
        mag2      = sign2 ? -bus.i_rs2 : bus.i_rs2;
        div_zero  = (bus.i_rs2 == 32'd0);
        div_ovf   = ~bus.i_op[0] && (bus.i_rs1 == 32'h8000_0000) && (bus.i_rs2 == 32'hFFFF_FFFF);

        // Multiply: acc holds {partial product high, remaining multiplier bits}.
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        product   = neg_q ? -mul_next : mul_next;

        // Divide: acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}.
        div_shift = {acc_q[63:32], acc_q[31]};
        div_ge    = div_shift >= {1'b0, opb_q};
        div_rem   = div_ge ? 32'(div_shift - {1'b0, opb_q}) : div_shift[31:0];
        div_quo   = {acc_q[30:0], div_ge};
        quo_res   = neg_q ? -div_quo : div_quo;
        rem_res   = rem_neg_q ? -div_rem : div_rem;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rdidx_d   = rdidx_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid && !bus.i_flush && (bus.i_rdidx != 5'd0)) begin
                    op_d      = bus.i_op;
                    rdidx_d   = bus.i_rdidx;
                    neg_d     = sign1 ^ sign2;
                    rem_neg_d = sign1;
                    cnt_d     = 6'd0;
                    if (!bus.i_op[2]) begin
                        state_d = MUL;
                        opb_d   = mag1;
                        acc_d   = {32'd0, mag2};
                    end else if (div_zero) begin
                        state_d  = DONE;
                        result_d = bus.i_op[1] ? bus.i_rs1 : 32'hFFFF_FFFF;
                    end else if (div_ovf) begin
                        state_d  = DONE;
                        result_d = bus.i_op[1] ? 32'd0 : 32'h8000_0000;
                    end else begin
                        state_d = DIV;
                        opb_d   = mag2;
                        acc_d   = {32'd0, mag1};
                    end
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    cnt_d    = 6'd0;
                    state_d  = DONE;
                    result_d = (op_q == 3'b000) ? product[31:0] : product[63:32];
                end
            end
            DIV: begin
                acc_d = {div_rem, div_quo};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    cnt_d    = 6'd0;
                    state_d  = DONE;
                    result_d = op_q[1] ? rem_res : quo_res;
                end
            end
            DONE: begin
                if (!bus.i_wb_wait) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            op_q      <= 3'd0;
            rdidx_q   <= 5'd0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            opb_q     <= 32'd0;
            acc_q     <= 64'd0;
            result_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rdidx_q   <= rdidx_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
        end
    end

    assign bus.o_mdu_working = (state_q != IDLE);
    assign bus.o_rdwen       = (state_q == DONE);
    assign bus.o_rdidx       = rdidx_q;
    assign bus.o_rdwdata     = result_q;
endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: issued ops push the reference result and due cycle,
// a negedge monitor pops and compares each result the unit presents.
module tb_mdu;
    logic clk = 1'b0;
    logic rstn;
    mdu_if bus ();

    mdu dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    bit   rand_wait = 1'b0;
    bit   forced_wait = 1'b0;

    always @(posedge clk) cycle++;

    // Write-back wait is either forced by the directed tests or randomly asserted.
    always @(posedge clk) begin
        #1;
        bus.i_wb_wait = rand_wait ? ($urandom_range(0, 3) == 0) : forced_wait;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, ua, ub, p;
        logic   ovf;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 0;
        case (op)
            3'd0: begin p = ua * ub;  return p[31:0];  end
            3'd1: begin p = sa * sb_; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb_; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb_; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the issue cycle.
    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd, output int n_acc);
        exp_t e;
        int   waited = 0;
        while (bus.o_mdu_working && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        check_output("issue_wait_budget", 32'(bus.o_mdu_working), 32'd0);
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_rs1   = a;
        bus.i_rs2   = b;
        bus.i_rdidx = rd;
        n_acc = cycle;
        if (rd != 0) begin
            e.rd   = rd;
            e.data = ref_model(op, a, b);
            e.due  = cycle + (is_special(op, a, b) ? 1 : 33);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((sb.size() != 0 || bus.o_mdu_working) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check_output("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic print_summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    endtask

    // Monitor: compares each presented result, its arrival cycle and its stability while held.
    initial begin
        bit   in_result;
        bit   after_consume;
        exp_t cur;
        in_result = 1'b0;
        after_consume = 1'b0;
        cur = '{rd: 5'd0, data: 32'd0, due: 0};
        forever begin
            @(negedge clk);
            if (!rstn) begin
                in_result = 1'b0;
                after_consume = 1'b0;
                continue;
            end
            if (after_consume) begin
                check_output("rdwen_after_consume", 32'(bus.o_rdwen), 32'd0);
                check_output("idle_after_consume", 32'(bus.o_mdu_working), 32'd0);
                after_consume = 1'b0;
            end else if (in_result) begin
                check_output("held_rdwen", 32'(bus.o_rdwen), 32'd1);
                check_output("held_rdidx", 32'(bus.o_rdidx), 32'(cur.rd));
                check_output("held_rdwdata", bus.o_rdwdata, cur.data);
                check_output("held_working", 32'(bus.o_mdu_working), 32'd1);
            end else if (bus.o_rdwen) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_rdwen", 32'(bus.o_rdwen), 32'd0);
                end else begin
                    cur = sb.pop_front();
                    in_result = 1'b1;
                    check_output("result_cycle", 32'(cycle), 32'(cur.due));
                    check_output("rdidx", 32'(bus.o_rdidx), 32'(cur.rd));
                    check_output("rdwdata", bus.o_rdwdata, cur.data);
                end
            end
            if (in_result && !bus.i_wb_wait) begin
                in_result = 1'b0;
                after_consume = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cycle);
        print_summary();
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;

        rstn        = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_op    = 3'd0;
        bus.i_rs1   = 32'd0;
        bus.i_rs2   = 32'd0;
        bus.i_rdidx = 5'd0;
        bus.i_wb_wait = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_working", 32'(bus.o_mdu_working), 32'd0);
        check_output("reset_rdwen", 32'(bus.o_rdwen), 32'd0);
        check_output("reset_rdidx", 32'(bus.o_rdidx), 32'd0);
        check_output("reset_rdwdata", bus.o_rdwdata, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed multiply/divide cases");
        apply_stimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, n); wait_done();
        apply_stimulus(3'd1, 32'd7, 32'hFFFF_FFFD, 5'd6, n); wait_done();
        apply_stimulus(3'd3, 32'd7, 32'hFFFF_FFFD, 5'd7, n); wait_done();
        apply_stimulus(3'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5'd8, n); wait_done();
        apply_stimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, n); wait_done();
        apply_stimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, n); wait_done();
        apply_stimulus(3'd5, 32'd100, 32'd7, 5'd11, n); wait_done();
        apply_stimulus(3'd7, 32'd100, 32'd7, 5'd12, n); wait_done();
        apply_stimulus(3'd5, 32'd5, 32'd0, 5'd13, n); wait_done();
        apply_stimulus(3'd6, 32'd5, 32'd0, 5'd14, n); wait_done();
        apply_stimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, n); wait_done();
        apply_stimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, n); wait_done();

        $display("[TB] write-back wait holds result");
        forced_wait = 1'b1;
        apply_stimulus(3'd0, 32'd12345, 32'd678, 5'd17, n);
        begin
            int t = 0;
            while (!bus.o_rdwen && t < 100) begin @(posedge clk); #1; t++; end
        end
        check_output("wait_reached_done", 32'(bus.o_rdwen), 32'd1);
        repeat (2) begin @(posedge clk); #1; end
        forced_wait = 1'b0;
        #1;
        check_output("wait_still_rdwen", 32'(bus.o_rdwen), 32'd1);
        @(posedge clk); #2;
        check_output("wait_release_rdwen", 32'(bus.o_rdwen), 32'd0);
        check_output("wait_release_idle", 32'(bus.o_mdu_working), 32'd0);
        @(posedge clk); #1;

        $display("[TB] flush behaviour");
        bus.i_flush = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_op    = 3'd0;
        bus.i_rdidx = 5'd3;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        check_output("flush_reject", 32'(bus.o_mdu_working), 32'd0);
        apply_stimulus(3'd0, 32'hDEAD_BEEF, 32'h0000_1234, 5'd18, n);
        repeat (9) begin @(posedge clk); #1; end
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        wait_done();

        $display("[TB] reset mid-operation and rd=0");
        apply_stimulus(3'd4, 32'd1000, 32'd3, 5'd19, n);
        repeat (14) begin @(posedge clk); #1; end
        rstn = 1'b0;
        #1;
        sb.delete();
        check_output("abort_working", 32'(bus.o_mdu_working), 32'd0);
        check_output("abort_rdwen", 32'(bus.o_rdwen), 32'd0);
        check_output("abort_rdidx", 32'(bus.o_rdidx), 32'd0);
        check_output("abort_rdwdata", bus.o_rdwdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        apply_stimulus(3'd7, 32'd1000, 32'd3, 5'd20, n); wait_done();
        apply_stimulus(3'd0, 32'd9, 32'd9, 5'd0, n);
        check_output("rd0_not_busy", 32'(bus.o_mdu_working), 32'd0);
        repeat (40) begin @(posedge clk); #1; end

        $display("[TB] randomized ops");
        rand_wait = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 50)) - 32'd25; b = 32'($urandom_range(1, 9)); end
                default: ;
            endcase
            rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            apply_stimulus(op, a, b, rd, n);
        end
        wait_done();
        rand_wait = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        print_summary();
        $finish;
    end
endmodule
